maxnet_host: RTL and testbench
==============================

MAXNET_HOST -- requirements
Module: maxnet_host

Interface
REQ-001 Parameter WIDTH, default 32: width of one input word.
REQ-002 Parameter ITER_BITS, default 8: width of the iteration counter and limit.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_data  input  WIDTH  input word.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 max_iter  input  ITER_BITS  iteration limit, sampled at job start.
REQ-009 ctrl_rst  output  1  active-high reset to the core controller.
REQ-010 dp_data  output  4*WIDTH  buffered words to the datapath, word0 in bits [WIDTH-1:0].
REQ-011 iter_pulse  input  1  pu_add_regs_en from the controller, one pulse per iteration.
REQ-012 done  input  1  controller done.
REQ-013 res_mux  input  2  controller winner index, valid while done=1.
REQ-014 force_end  output  1  ORed externally into the controller end_signal.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer takes the result.
REQ-017 out_winner  output  2  captured res_mux.
REQ-018 out_iters  output  ITER_BITS  iterations counted for this job.
REQ-019 out_timeout  output  1  job ended by force_end, not naturally.

Function
REQ-020 The FSM SHALL have states IDLE, FILL, KICK, RUN, HOLD.
REQ-021 IDLE: in_ready=1. An accepted word (in_valid & in_ready) SHALL be stored in slot 0, then FILL.
REQ-022 FILL: in_ready=1. Each accepted word SHALL go to the next slot (1..3). After slot 3, KICK.
REQ-023 In RUN/KICK/HOLD, in_ready SHALL be 0, and words offered there SHALL be ignored.
REQ-024 dp_data SHALL hold the 4 slots and stay stable from KICK until the next IDLE->FILL acceptance.
REQ-025 On IDLE->FILL, max_iter SHALL be latched; the iteration counter SHALL be cleared.
REQ-026 KICK SHALL last exactly 2 cycles with ctrl_rst=1, then RUN. ctrl_rst SHALL be 0 in every other state.
REQ-027 RUN: each iter_pulse SHALL increment the counter, saturating at 2^ITER_BITS-1.
REQ-028 force_end SHALL be 1 in RUN when counter >= latched limit, else 0; the timeout flag SHALL be set on the first such cycle.
REQ-029 Latched limit 0: force_end SHALL be 1 from the first RUN cycle.
REQ-030 RUN with done=1: out_winner<=res_mux, out_iters<=counter (including any iter_pulse in the same cycle), out_timeout<=flag, then HOLD.
REQ-031 HOLD: out_valid=1, outputs stable; on out_ready=1, IDLE on the next cycle.
REQ-032 HOLD->IDLE SHALL NOT accept input in the transition cycle; in_ready SHALL rise in IDLE.
REQ-033 done and iter_pulse outside RUN SHALL be ignored.

Reset
REQ-034 rst=0 at a clock edge SHALL force IDLE and clear slots, counter, limit, flag, out_winner, out_iters and out_timeout.
REQ-035 During reset: in_ready=0, out_valid=0, force_end=0, ctrl_rst=1, so the controller is held in reset.
REQ-036 First cycle after reset release: ctrl_rst=0 and in_ready=1.
REQ-037 Reset asserted mid-job (FILL/KICK/RUN/HOLD) SHALL abandon the job with no out_valid pulse.

Verification
REQ-038 Natural end: load words 5,9,2,7, max_iter=10, 3 iter_pulses, then done with res_mux=1 -> ctrl_rst high exactly 2 cycles; out_valid with winner=1, iters=3, timeout=0; force_end never 1.
REQ-039 Timeout: max_iter=4, continuous iter_pulse -> force_end rises the cycle after the 4th pulse is counted; done with res_mux=2 yields iters>=4, timeout=1.
REQ-040 Backpressure: out_ready held 0 for 5 cycles in HOLD -> outputs stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-041 Input gaps: in_valid toggling 1,0,1,0,... with words A..D -> dp_data = {D,C,B,A}; KICK only after the 4th accept.
REQ-042 Reset mid-RUN: rst=0 for 1 cycle after 2 iter_pulses -> IDLE, out_valid never 1, ctrl_rst=1 during reset; next job counts from 0.
REQ-043 Limit 0 and saturation: max_iter=0 -> force_end on first RUN cycle; ITER_BITS=2 with 6 pulses -> out_iters=3.

Source files
------------

// File: rtl/maxnet_host.sv
// Host-side sequencer for the MAXNET core: buffers four input words, resets
// the controller, bounds the iteration count and holds the result for the consumer.
module maxnet_host #(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [ITER_BITS-1:0]   max_iter,
    output logic                   ctrl_rst,
    output logic [4*WIDTH-1:0]     dp_data,
    input  logic                   iter_pulse,
    input  logic                   done,
    input  logic [1:0]             res_mux,
    output logic                   force_end,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_winner,
    output logic [ITER_BITS-1:0]   out_iters,
    output logic                   out_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_KICK,
        S_RUN,
        S_HOLD
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0][WIDTH-1:0]  slots;
    logic [1:0]             fill_idx;
    logic                   kick_cnt;
    logic [ITER_BITS-1:0]   iter_cnt;
    logic [ITER_BITS-1:0]   limit;
    logic                   tmo_flag;
    logic                   accept;
    logic                   iter_inc;
    logic [ITER_BITS-1:0]   cnt_nxt;

    assign accept   = in_valid & in_ready;
    assign dp_data  = slots;

    // Counter saturates at all-ones instead of wrapping.
    assign iter_inc = iter_pulse && (iter_cnt != {ITER_BITS{1'b1}});
    assign cnt_nxt  = iter_cnt + (iter_inc ? ITER_BITS'(1) : ITER_BITS'(0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_FILL;
            end
            S_FILL: begin
                if (accept && fill_idx == 2'd3) state_nxt = S_KICK;
            end
            S_KICK: begin
                if (kick_cnt) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (done) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The controller is held in reset whenever this block is in reset.
    always_comb begin
        in_ready  = 1'b0;
        ctrl_rst  = 1'b0;
        force_end = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            ctrl_rst = 1'b1;
        end else begin
            case (state)
                S_IDLE: in_ready = 1'b1;
                S_FILL: in_ready = 1'b1;
                S_KICK: ctrl_rst = 1'b1;
                S_RUN:  force_end = (iter_cnt >= limit);
                S_HOLD: out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slots       <= '0;
            fill_idx    <= 2'd0;
            kick_cnt    <= 1'b0;
            iter_cnt    <= '0;
            limit       <= '0;
            tmo_flag    <= 1'b0;
            out_winner  <= 2'd0;
            out_iters   <= '0;
            out_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        slots[0] <= in_data;
                        fill_idx <= 2'd1;
                        limit    <= max_iter;
                        iter_cnt <= '0;
                        tmo_flag <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        slots[fill_idx] <= in_data;
                        fill_idx        <= fill_idx + 2'd1;
                        kick_cnt        <= 1'b0;
                    end
                end
                S_KICK: begin
                    kick_cnt <= 1'b1;
                end
                S_RUN: begin
                    iter_cnt <= cnt_nxt;
                    if (force_end) tmo_flag <= 1'b1;
                    // A done coinciding with the first forced cycle still counts as a timeout.
                    if (done) begin
                        out_winner  <= res_mux;
                        out_iters   <= cnt_nxt;
                        out_timeout <= tmo_flag | force_end;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_host.sv
// Bench for maxnet_host: table-driven jobs, hand sequences for reset and
// saturation, and randomized jobs checked against a job-level model.
module tb_maxnet_host;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [7:0]   max_iter;
    logic         ctrl_rst;
    logic [127:0] dp_data;
    logic         iter_pulse;
    logic         done;
    logic [1:0]   res_mux;
    logic         force_end;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_winner;
    logic [7:0]   out_iters;
    logic         out_timeout;

    logic         b_rst;
    logic         b_in_valid;
    logic [7:0]   b_in_data;
    logic         b_in_ready;
    logic [1:0]   b_max_iter;
    logic         b_ctrl_rst;
    logic [31:0]  b_dp_data;
    logic         b_iter_pulse;
    logic         b_done;
    logic [1:0]   b_res_mux;
    logic         b_force_end;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [1:0]   b_out_winner;
    logic [1:0]   b_out_iters;
    logic         b_out_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    maxnet_host #(.WIDTH(32), .ITER_BITS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .max_iter(max_iter), .ctrl_rst(ctrl_rst),
        .dp_data(dp_data), .iter_pulse(iter_pulse), .done(done),
        .res_mux(res_mux), .force_end(force_end), .out_valid(out_valid),
        .out_ready(out_ready), .out_winner(out_winner),
        .out_iters(out_iters), .out_timeout(out_timeout)
    );

    maxnet_host #(.WIDTH(8), .ITER_BITS(2)) dut_sat (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .max_iter(b_max_iter), .ctrl_rst(b_ctrl_rst),
        .dp_data(b_dp_data), .iter_pulse(b_iter_pulse), .done(b_done),
        .res_mux(b_res_mux), .force_end(b_force_end), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_winner(b_out_winner),
        .out_iters(b_out_iters), .out_timeout(b_out_timeout)
    );

    typedef struct {
        logic [127:0] words;
        int           lim;
        int           npulse;
        int           run_len;
        logic [1:0]   win;
        int           hold;
        bit           gaps;
        int           exp_it;
        int           exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load_words(input logic [127:0] words, input int lim, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
                chk("gap_ctrl_rst", 128'(ctrl_rst), 128'(0));
            end
            chk("fill_ready", 128'(in_ready), 128'(1));
            in_valid = 1'b1;
            in_data  = words[i*32 +: 32];
            if (i == 0) max_iter = 8'(lim);
            tick();
            max_iter = 8'($urandom);
        end
        in_valid = 1'b1;
        in_data  = $urandom;
        chk("kick1_ctrl_rst", 128'(ctrl_rst), 128'(1));
        chk("kick1_ready", 128'(in_ready), 128'(0));
        chk("kick_dp_data", dp_data, words);
        done       = 1'b1;
        iter_pulse = 1'b1;
        tick();
        chk("kick2_ctrl_rst", 128'(ctrl_rst), 128'(1));
        chk("kick2_force_end", 128'(force_end), 128'(0));
        tick();
        done       = 1'b0;
        iter_pulse = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int cnt;
        bit tmo;
        bit p;
        int e_it;
        int e_to;
        load_words(v.words, v.lim, v.gaps);
        cnt = 0;
        tmo = 1'b0;
        for (int c = 0; c <= v.run_len; c++) begin
            if (c == 0) chk("run_ctrl_rst", 128'(ctrl_rst), 128'(0));
            chk("run_force_end", 128'(force_end), 128'(cnt >= v.lim));
            chk("run_ready", 128'(in_ready), 128'(0));
            if (cnt >= v.lim) tmo = 1'b1;
            if (v.npulse < 0) p = ($urandom % 100) < 60;
            else p = (c < v.npulse);
            iter_pulse = p;
            done       = (c == v.run_len);
            res_mux    = (c == v.run_len) ? v.win : 2'($urandom);
            if (p && cnt < 255) cnt++;
            tick();
        end
        e_it = (v.exp_it < 0) ? cnt : v.exp_it;
        e_to = (v.exp_to < 0) ? int'(tmo) : v.exp_to;
        for (int h = 0; h <= v.hold; h++) begin
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_winner", 128'(out_winner), 128'(v.win));
            chk("hold_iters", 128'(out_iters), 128'(e_it));
            chk("hold_timeout", 128'(out_timeout), 128'(e_to));
            chk("hold_ready", 128'(in_ready), 128'(0));
            chk("hold_force_end", 128'(force_end), 128'(0));
            iter_pulse = 1'($urandom);
            done       = 1'($urandom);
            res_mux    = 2'($urandom);
            out_ready  = (h == v.hold);
            tick();
        end
        out_ready  = 1'b0;
        iter_pulse = 1'b0;
        done       = 1'b0;
        in_valid   = 1'b0;
        chk("idle_valid", 128'(out_valid), 128'(0));
        chk("idle_ready", 128'(in_ready), 128'(1));
        chk("idle_iters_kept", 128'(out_iters), 128'(e_it));
    endtask

    initial begin
        vec_t rv;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; max_iter = '0;
        iter_pulse = 1'b0; done = 1'b0; res_mux = '0; out_ready = 1'b0;
        b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_max_iter = '0;
        b_iter_pulse = 1'b0; b_done = 1'b0; b_res_mux = '0; b_out_ready = 1'b0;

        vecs[0] = '{{32'd7, 32'd2, 32'd9, 32'd5}, 10, 3, 5, 2'd1, 0, 1'b0, 3, 0};
        vecs[1] = '{{32'd4, 32'd3, 32'd2, 32'd1}, 4, 1000, 8, 2'd2, 0, 1'b0, 9, 1};
        vecs[2] = '{{32'h11, 32'h22, 32'h33, 32'h44}, 20, 2, 3, 2'd3, 5, 1'b0, 2, 0};
        vecs[3] = '{{32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001},
                    1, 0, 2, 2'd0, 1, 1'b1, 0, 0};
        vecs[4] = '{{32'h0, 32'h1, 32'h2, 32'h3}, 0, 0, 1, 2'd1, 0, 1'b0, 0, 1};
        vecs[5] = '{{32'hF0, 32'hE0, 32'hD0, 32'hC0}, 255, 300, 299, 2'd2, 0, 1'b0, 255, 1};

        tick();
        tick();
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_force_end", 128'(force_end), 128'(0));
        chk("rst_ctrl_rst", 128'(ctrl_rst), 128'(1));
        chk("rst_dp_data", dp_data, 128'(0));
        chk("rst_iters", 128'(out_iters), 128'(0));
        chk("rst_winner", 128'(out_winner), 128'(0));
        chk("rst_timeout", 128'(out_timeout), 128'(0));
        rst = 1'b1;
        b_rst = 1'b1;
        #1;
        chk("rel_ctrl_rst", 128'(ctrl_rst), 128'(0));
        chk("rel_ready", 128'(in_ready), 128'(1));

        // done / iter_pulse while idle must be ignored
        done = 1'b1; iter_pulse = 1'b1;
        tick();
        done = 1'b0; iter_pulse = 1'b0;
        chk("idle_done_ignored", 128'(out_valid), 128'(0));

        foreach (vecs[i]) run_job(vecs[i]);

        // Reset in the middle of RUN
        load_words({32'd8, 32'd6, 32'd4, 32'd2}, 10, 1'b0);
        iter_pulse = 1'b1;
        tick();
        tick();
        iter_pulse = 1'b0;
        chk("mid_run_valid", 128'(out_valid), 128'(0));
        rst = 1'b0;
        #1;
        chk("midrst_ctrl_rst", 128'(ctrl_rst), 128'(1));
        chk("midrst_ready", 128'(in_ready), 128'(0));
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_force_end", 128'(force_end), 128'(0));
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'(1));
        chk("post_rst_ctrl_rst", 128'(ctrl_rst), 128'(0));
        chk("post_rst_dp_data", dp_data, 128'(0));
        chk("post_rst_valid", 128'(out_valid), 128'(0));
        rv = '{{32'd1, 32'd1, 32'd1, 32'd1}, 10, 1, 2, 2'd2, 0, 1'b0, 1, 0};
        run_job(rv);

        // Two-bit counter saturates at 3
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(i + 1);
            b_max_iter = 2'd3;
            tick();
        end
        b_in_valid = 1'b0;
        chk("sat_dp_data", 128'(b_dp_data), 128'(32'h04030201));
        tick();
        tick();
        chk("sat_ctrl_rst", 128'(b_ctrl_rst), 128'(0));
        for (int c = 0; c < 6; c++) begin
            if (c == 3) chk("sat_force_end", 128'(b_force_end), 128'(1));
            b_iter_pulse = 1'b1;
            b_done       = (c == 5);
            b_res_mux    = 2'd3;
            tick();
        end
        b_iter_pulse = 1'b0;
        b_done       = 1'b0;
        chk("sat_valid", 128'(b_out_valid), 128'(1));
        chk("sat_iters", 128'(b_out_iters), 128'(3));
        chk("sat_timeout", 128'(b_out_timeout), 128'(1));
        chk("sat_winner", 128'(b_out_winner), 128'(3));
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("sat_idle_ready", 128'(b_in_ready), 128'(1));

        // Randomized jobs against the job-level model
        for (int k = 0; k < 15; k++) begin
            rv.words   = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            rv.lim     = int'($urandom_range(0, 12));
            rv.npulse  = -1;
            rv.run_len = int'($urandom_range(0, 15));
            rv.win     = 2'($urandom);
            rv.hold    = int'($urandom_range(0, 3));
            rv.gaps    = 1'($urandom);
            rv.exp_it  = -1;
            rv.exp_to  = -1;
            run_job(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
